// File: rtl/hex_scan_pkg.sv
// Shared types and helpers for the hex_scan_ctrl 7-segment scan controller.
// Build option: HEX_SCAN_LZ_BLANK_EN enables leading-zero blanking in hex_scan_ctrl.
package hex_scan_pkg;

    localparam int NIB_W = 4;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // Register width for a counter spanning 0..n-1 (never narrower than one bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hex_scan_tick.sv
// Slot prescaler and digit index for the scan controller.
// Provides combinational strobes for the last cycle of a slot and of a frame.
module hex_scan_tick
    import hex_scan_pkg::*;
#(
    parameter int PRESCALE   = 50000,
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic [cnt_w(PRESCALE)-1:0]    count,
    output logic [cnt_w(NUM_DIGITS)-1:0]  index,
    output logic                          slot_wrap,
    output logic                          frame_wrap
);

    localparam int CNT_W = cnt_w(PRESCALE);
    localparam int IDX_W = cnt_w(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] index_q, index_d;

    always_comb begin
        slot_wrap  = (count_q == CNT_LAST);
        frame_wrap = slot_wrap && (index_q == IDX_LAST);
        count_d    = count_q + CNT_W'(1);
        index_d    = index_q;
        if (slot_wrap) begin
            count_d = '0;
            index_d = frame_wrap ? '0 : index_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            index_q <= '0;
        end else begin
            count_q <= count_d;
            index_q <= index_d;
        end
    end

    assign count = count_q;
    assign index = index_q;

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits sharing one decoder.
// Build option: define HEX_SCAN_LZ_BLANK_EN to darken leading-zero digits (digit 0 always shown).
module hex_scan_ctrl
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NIB_W*NUM_DIGITS-1:0]   upd_data,
    input  logic                          upd_valid,
    output logic                          upd_ready,
    input  logic [NUM_DIGITS-1:0]         digit_en,
    output logic [NIB_W-1:0]              nib_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int CNT_W  = cnt_w(PRESCALE);
    localparam int IDX_W  = cnt_w(NUM_DIGITS);
    localparam int DATA_W = NIB_W * NUM_DIGITS;

    if (NUM_DIGITS < 1) begin : g_bad_digits
        $error("hex_scan_ctrl: NUM_DIGITS must be >= 1");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("hex_scan_ctrl: PRESCALE must be >= 2");
    end
    if (BLANK_CYCLES >= PRESCALE) begin : g_bad_blank
        $error("hex_scan_ctrl: BLANK_CYCLES must be < PRESCALE");
    end

    logic [CNT_W-1:0]      count;
    logic [IDX_W-1:0]      index;
    logic                  slot_wrap;
    logic                  frame_wrap;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     disp_q, disp_d;
    logic [DATA_W-1:0]     pend_q, pend_d;
    logic                  pend_full_q, pend_full_d;
    logic [NIB_W-1:0]      nib_q, nib_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_tick_q, frame_tick_d;
    logic [NUM_DIGITS-1:0] lz_off;
    logic                  xfer;

    hex_scan_tick #(
        .PRESCALE   (PRESCALE),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .count      (count),
        .index      (index),
        .slot_wrap  (slot_wrap),
        .frame_wrap (frame_wrap)
    );

    // State mirrors the counter: BLANK for the first BLANK_CYCLES counts of a slot.
    always_comb begin
        state_d = state_q;
        if (slot_wrap) begin
            state_d = (BLANK_CYCLES == 0) ? SHOW : BLANK;
        end else if (int'(count) + 1 == BLANK_CYCLES) begin
            state_d = SHOW;
        end
    end

    // Pending slot holds one update; it only reaches the display on a frame wrap.
    always_comb begin
        xfer        = upd_valid && !pend_full_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        disp_d      = disp_q;
        if (frame_wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end else if (xfer) begin
            pend_d      = upd_data;
            pend_full_d = 1'b1;
        end
    end

`ifdef HEX_SCAN_LZ_BLANK_EN
    logic upper_zero;

    always_comb begin
        lz_off     = '0;
        upper_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            upper_zero = upper_zero && (disp_q[i*NIB_W +: NIB_W] == '0);
            lz_off[i]  = upper_zero;
        end
    end
`else
    assign lz_off = '0;
`endif

    // Nibble is driven in BLANK too so the external decoder settles before the anode turns on.
    always_comb begin
        nib_d        = disp_q[int'(index)*NIB_W +: NIB_W];
        an_d         = '1;
        frame_tick_d = frame_wrap;
        if ((state_q == SHOW) && digit_en[index] && !lz_off[index]) begin
            an_d[index] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BLANK;
            disp_q       <= '0;
            pend_full_q  <= 1'b0;
            nib_q        <= '0;
            an_q         <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_q       <= disp_d;
            pend_full_q  <= pend_full_d;
            nib_q        <= nib_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Contents are meaningless while the pending flag is clear, so no reset is needed.
    always_ff @(posedge clk) begin
        pend_q <= pend_d;
    end

    assign upd_ready  = !pend_full_q;
    assign nib_out    = nib_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: doc/hex_scan_ctrl.md
Name: hex_scan_ctrl

Overview:
- Time-multiplexed scan controller for a bank of common-anode 7-segment digits that share one 4-bit-to-7-segment decoder.
- Holds a multi-digit value, rotates through the digits at a programmable slot rate and drives the decoder's 4-bit input plus active-low anode enables.
- Inserts a blanking gap between digits to prevent ghosting.
- Accepts new values through a valid/ready handshake and commits them only at frame boundaries, so a displayed frame never mixes old and new digits.

Parameters:
- NUM_DIGITS, 4: number of scanned digits; must be ≥ 1.
- PRESCALE, 50000: clk cycles per digit slot; must be ≥ 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all anodes off; must be < PRESCALE.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- upd_data  in  4*NUM_DIGITS  new value; nibble i drives digit i, and digit 0 is least significant.
- upd_valid  in  1  upd_data is valid.
- upd_ready  out  1  pending register is empty, so the block can accept upd_data.
- digit_en  in  NUM_DIGITS  per-digit enable; 0 keeps that digit's anode off.
- nib_out  out  4  nibble for the shared decoder.
- an  out  NUM_DIGITS  anode enables, active-low (1 = off).
- frame_tick  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - slot counter=0, digit index=0, state=BLANK.
  - an=all 1s, nib_out=0, frame_tick=0.
  - display register=0, pending register empty, upd_ready=1.
  - Reset mid-slot or mid-handshake discards the pending value.
- Slot counter:
  - Width is $clog2(PRESCALE); counts 0..PRESCALE-1 and then wraps to 0.
  - Digit index advances on the wrap. It goes from NUM_DIGITS-1 to 0 (a frame wrap).
- FSM has two states, derived from the counter:
  - BLANK while counter < BLANK_CYCLES.
  - SHOW while counter ≥ BLANK_CYCLES.
  - BLANK→SHOW when counter reaches BLANK_CYCLES.
  - SHOW→BLANK on counter wrap.
- Outputs are registered, with one cycle of lag behind the counter/state:
  - nib_out = display nibble[index] in both states, so the decoder settles during BLANK.
  - an[index] = 0 only in SHOW with digit_en[index]=1; all other anode bits are 1.
  - A digit_en change takes effect on the next cycle.
- Handshake:
  - A transfer occurs when upd_valid & upd_ready. upd_data is captured into the pending register, and upd_ready drops next cycle.
- Commit:
  - On a frame-wrap cycle with the pending register full, pending is copied to the display register and the pending register empties.
  - upd_ready returns to 1 the cycle after the commit.
  - The new value is first shown on digit 0 of the new frame.
  - A transfer and a frame wrap in the same cycle with pending empty: the data is accepted, but commits at the following frame wrap.
- frame_tick is asserted for exactly one cycle, registered, on the cycle after each frame wrap. It is not asserted after reset until the first wrap.
- NUM_DIGITS=1: index stays 0 and every slot wrap is a frame wrap.

Optional Feature:
- Macro: HEX_SCAN_LZ_BLANK_EN (leading-zero blanking).
- Defined: digit i>0 has its anode forced off if nibbles i..NUM_DIGITS-1 of the display register are all 0. Digit 0 is never suppressed. Suppression is evaluated from the display register, not the pending register.
- Undefined: all enabled digits are shown; no extra logic.

Decomposition:
- Package hex_scan_pkg contains:
  - state enum {BLANK, SHOW};
  - localparam helper for counter width;
  - NIB_W=4.
- Sub-module hex_scan_tick: prescaler counter with wrap and frame_wrap strobes (parameters PRESCALE, NUM_DIGITS; outputs count, index, slot_wrap, frame_wrap).
- The FSM, handshake and registers stay in hex_scan_ctrl.
- The segment decoder is external; nib_out feeds it.

Test Plan (NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless noted):
- Reset release, then upd_data=16'h4321 accepted → frame 1 shows 0; from frame 2:
  - an sequence 1110/1101/1011/0111, each low for 6 cycles, with 2 cycles of 1111 between digits;
  - nib_out = 1,2,3,4 per slot.
- Handshake back-pressure: accept 16'hAAAA mid-frame, then hold upd_valid with 16'hBBBB → upd_ready=0 until the cycle after the wrap; then AAAA is displayed; BBBB is accepted and displayed one frame later.
- Transfer on the exact frame-wrap cycle with pending empty → the value is not shown in the next frame, is shown in the one after, and frame_tick pulses once per frame (every 32 cycles).
- digit_en=4'b0101 with value 16'h1234 → an never drives digit 1 or 3 low; digits 0 and 2 are shown as normal; the slot timing is unchanged.
- Assert rst_n=0 for 1 cycle mid-SHOW on digit 2 with pending full → next cycle an=1111, upd_ready=1, display register=0; the scan restarts at digit 0.
- With HEX_SCAN_LZ_BLANK_EN defined:
  - value 16'h0050 → digits 3 and 2 stay dark; digits 1 and 0 are lit (nibbles 5 and 0).
  - value 16'h0000 → only digit 0 is lit.
